// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: accepts host words, shifts them MSB-first onto ccff_head and gates prog_clk.
// Optional CRC-8 signatures of the bits shifted in and out are built when CCFF_CRC_EN is defined.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 8,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_CRC_EN
  ,
  output logic [7:0]        crc_head,
  output logic [7:0]        crc_tail
`endif
);

  localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  WORD_LAST    = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [WB_W-1:0]   wbit_reg;
  logic              head_reg;
  logic              clk_en_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  bit_count_reg;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_reg     <= S_IDLE;
      shreg_reg     <= '0;
      wbit_reg      <= '0;
      head_reg      <= 1'b0;
      clk_en_reg    <= 1'b0;
      done_reg      <= 1'b0;
      bit_count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_LOAD;
            bit_count_reg <= '0;
          end
        end
        S_LOAD: begin
          // Chain frozen while waiting; head keeps the last bit shifted.
          clk_en_reg <= 1'b0;
          if (cfg_valid) begin
            shreg_reg <= cfg_data;
            wbit_reg  <= '0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          head_reg      <= shreg_reg[WORD_W-1];
          clk_en_reg    <= 1'b1;
          shreg_reg     <= shreg_reg << 1;
          bit_count_reg <= bit_count_reg + 1'b1;
          // The chain length wins over the word boundary: leftover word bits are dropped.
          if (bit_count_reg == LAST_BIT_CNT) begin
            state_reg <= S_DONE;
          end else if (wbit_reg == WORD_LAST) begin
            state_reg <= S_LOAD;
          end else begin
            wbit_reg <= wbit_reg + 1'b1;
          end
        end
        S_DONE: begin
          clk_en_reg <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready   = (state_reg == S_LOAD);
  assign busy        = (state_reg != S_IDLE);
  assign ccff_head   = head_reg;
  assign ccff_clk_en = clk_en_reg;
  assign done        = done_reg;
  assign bit_count   = bit_count_reg;

`ifdef CCFF_CRC_EN
  localparam logic [7:0] CRC_POLY = 8'h07;

  // Lane 0 signs the bits entering the chain, lane 1 the old contents leaving it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_crc_lane
    logic       fold_bit;
    logic [7:0] crc_reg;
    logic [7:0] crc_next;

    if (gi == 0) begin : g_head
      assign fold_bit = head_reg;
    end else begin : g_tail
      assign fold_bit = ccff_tail;
    end

    assign crc_next = {crc_reg[6:0], 1'b0} ^ (CRC_POLY & {8{crc_reg[7] ^ fold_bit}});

    always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
        crc_reg <= '0;
      end else if (state_reg == S_IDLE && start) begin
        crc_reg <= '0;
      end else if (clk_en_reg) begin
        crc_reg <= crc_next;
      end
    end
  end

  assign crc_head = g_crc_lane[0].crc_reg;
  assign crc_tail = g_crc_lane[1].crc_reg;
`else
  logic unused_ccff_tail;
  assign unused_ccff_tail = ccff_tail;
`endif

endmodule
